instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction memory read port: owns the PC, drives the
//  64-bit byte address, captures the returned 32-bit word the same cycle and

---
 rtl/instruction_fetch_unit_if.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit boundary: instruction memory read port, redirect input,
// decode-side valid/ready stream and halt status.
interface instruction_fetch_unit_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, halted,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, halted,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, reads one word per cycle from a combinational instruction memory
// and buffers {pc, instr} in a small FIFO toward decode; halts on ECALL/range.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] ECALL_WORD = 32'h00000073
) (
    input  logic                          clk,
    input  logic                          rst_n,
    instruction_fetch_unit_if.master      bus
);
    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [63:0]   PC_LIMIT = 64'(4 * IMEM_WORDS);

    typedef enum logic {RUN, HALT} state_e;

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [63:0]   buf_pc    [FIFO_DEPTH];
    logic [31:0]   buf_instr [FIFO_DEPTH];

    logic push, pop, flush;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign pop           = (count_q != '0) && bus.out_ready;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = bus.out_valid ? buf_pc[rd_ptr_q]    : 64'h0;
    assign bus.out_instr = bus.out_valid ? buf_instr[rd_ptr_q] : 32'h0;
    assign bus.halted    = (state_q == HALT) && (count_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (bus.redirect_valid) begin
            flush   = 1'b1;
            pc_d    = {bus.redirect_pc[63:2], 2'b00};
            state_d = RUN;
        end else if (state_q == RUN && pc_q >= PC_LIMIT) begin
            state_d = HALT;
        end else if (state_q == RUN && count_q < DEPTH_C) begin
            // Space is judged on the registered count; a same-cycle pop does not help.
            push = 1'b1;
            pc_d = pc_q + 64'd4;
            if (bus.imem_instr == ECALL_WORD) state_d = HALT;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr_q]    <= pc_q;
            buf_instr[wr_ptr_q] <= bus.imem_instr;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;
    logic clk, rst_n;
    logic [31:0] mem [0:1023];
    int vecs = 0;
    int errs = 0;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.imem_instr = mem[bus.imem_addr[11:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h00000013;
        mem[0] = 32'h00000093; mem[1] = 32'h00100113; mem[2] = 32'h002081b3;
        mem[3] = 32'h00310233; mem[4] = 32'h002182b3; mem[6] = 32'h00000073;
        mem[1023] = 32'h00a00093;

        rst_n = 1'b0; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 64'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid",  64'(bus.out_valid), 64'h0);
        chk("rst_halted", 64'(bus.halted),    64'h0);
        chk("rst_addr",   bus.imem_addr,      64'h0);
        chk("rst_pc",     bus.out_pc,         64'h0);
        chk("rst_instr",  64'(bus.out_instr), 64'h0);

        // Streaming with ready high, running into the ECALL at 0x18
        rst_n = 1'b1; bus.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("stream_valid", 64'(bus.out_valid), 64'h1);
            chk("stream_pc",    bus.out_pc,         64'(4 * k));
            chk("stream_instr", 64'(bus.out_instr), 64'(mem[k]));
        end
        for (int k = 0; k < 2; k++) begin
            step();
            chk("ecall_valid",  64'(bus.out_valid), 64'h0);
            chk("ecall_halted", 64'(bus.halted),    64'h1);
            chk("ecall_addr",   bus.imem_addr,      64'h1c);
        end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0;
        step();
        bus.redirect_valid = 1'b0;
        chk("resume_halted", 64'(bus.halted),    64'h0);
        chk("resume_valid",  64'(bus.out_valid), 64'h0);
        chk("resume_addr",   bus.imem_addr,      64'h0);
        step();
        chk("resume_pc",    bus.out_pc,         64'h0);
        chk("resume_instr", 64'(bus.out_instr), 64'h93);
        chk("resume_addr2", bus.imem_addr,      64'h4);

        // Asynchronous reset between edges
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",  64'(bus.out_valid), 64'h0);
        chk("arst_halted", 64'(bus.halted),    64'h0);
        chk("arst_addr",   bus.imem_addr,      64'h0);
        bus.out_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Backpressure: buffer fills with 0,4 and pc parks at 8
        repeat (5) step();
        chk("bp_addr",  bus.imem_addr,      64'h8);
        chk("bp_valid", 64'(bus.out_valid), 64'h1);
        chk("bp_pc0",   bus.out_pc,         64'h0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_pc1", bus.out_pc, 64'h4);
        step();
        chk("bp_pc2",    bus.out_pc,         64'h8);
        chk("bp_instr2", 64'(bus.out_instr), 64'h002081b3);

        // Redirect while full, with a same-cycle pop
        rst_n = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step(); step();
        chk("full_addr", bus.imem_addr, 64'h8);
        chk("full_pc",   bus.out_pc,    64'h0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h13; bus.out_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir_valid", 64'(bus.out_valid), 64'h0);
        chk("redir_addr",  bus.imem_addr,      64'h10);
        step();
        chk("redir_pc",    bus.out_pc,         64'h10);
        chk("redir_instr", 64'(bus.out_instr), 64'h002182b3);
        chk("redir_addr2", bus.imem_addr,      64'h14);

        // Last legal word, then out-of-range halt
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hffc;
        step();
        bus.redirect_valid = 1'b0;
        chk("edge_addr",  bus.imem_addr,      64'hffc);
        chk("edge_valid", 64'(bus.out_valid), 64'h0);
        step();
        chk("edge_pc",    bus.out_pc,         64'hffc);
        chk("edge_instr", 64'(bus.out_instr), 64'h00a00093);
        chk("edge_addr2", bus.imem_addr,      64'h1000);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("oor_valid",  64'(bus.out_valid), 64'h0);
            chk("oor_halted", 64'(bus.halted),    64'h1);
            chk("oor_addr",   bus.imem_addr,      64'h1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
